// File: rtl/serial_sub_pkg.sv
// -----------------------------------------------------------------------------
// serial_sub_pkg
// Shared types and constants for the bit-serial subtractor.
//   state_e         : FSM state encoding (IDLE, RUN)
//   DEFAULT_WIDTH   : default operand width
//   cnt_width()     : bit-counter width for a given operand width
//   DEFAULT_CNT_W   : counter width for the default operand width
// -----------------------------------------------------------------------------
package serial_sub_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int DEFAULT_WIDTH = 16;

    // The counter must be able to hold WIDTH itself (it increments past the
    // last bit index on the final cycle), hence WIDTH+1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
// Single-bit gate-level full subtractor: D = A - B - Bi.
//   A  : minuend bit
//   B  : subtrahend bit
//   Bi : borrow in
//   D  : difference bit
//   Bo : borrow out
// -----------------------------------------------------------------------------
module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic Bi,
    output logic D,
    output logic Bo
);

    assign D  = A ^ B ^ Bi;
    assign Bo = (~A & B) | (~(A ^ B) & Bi);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial unsigned subtractor Z = X - Y, one bit per clock, LSB first,
// using a single full_subtractor cell and a borrow flop.
//
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   start : request, only sampled while idle
//   X, Y  : minuend / subtrahend, captured on the accepting edge
//   busy  : high while an operation is in progress
//   done  : one-cycle pulse when Z/ovf have just been updated
//   Z     : {borrow-out, (X - Y) mod 2^WIDTH}, held until next completion
//   ovf   : signed overflow of X - Y (only with SERIAL_SUB_OVF_EN)
//
// Configuration macro: SERIAL_SUB_OVF_EN enables the signed-overflow flag.
// Without it, ovf is tied low and the overflow logic is not built.
// -----------------------------------------------------------------------------
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   Z,
    output logic             ovf
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    // Only WIDTH-1 result bits are stored: the final difference bit goes
    // straight from the cell into Z on the completing edge.
    logic [WIDTH-2:0]   res_q, res_d;
    logic [WIDTH-2:0]   res_shift;
    logic               borrow_q, borrow_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     z_q, z_d;
    logic               done_q, done_d;

    logic               cell_d;
    logic               cell_bo;
    logic               last_bit;
    logic               accept;
    logic               finish;

    full_subtractor u_cell (
        .A  (a_q[0]),
        .B  (b_q[0]),
        .Bi (borrow_q),
        .D  (cell_d),
        .Bo (cell_bo)
    );

    // Result shift register: new bit enters at the top, so after WIDTH-1
    // shifts bit 0 of the difference sits at res_q[0].
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_res_shift
            if (gi == WIDTH - 2) begin : g_top
                assign res_shift[gi] = cell_d;
            end else begin : g_mid
                assign res_shift[gi] = res_q[gi+1];
            end
        end
    endgenerate

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    assign accept   = (state_q == IDLE) && start;
    assign finish   = (state_q == RUN) && last_bit;

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        z_d      = z_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d      = X;
                    b_d      = Y;
                    res_d    = '0;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                res_d    = res_shift;
                borrow_d = cell_bo;
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    z_d     = {cell_bo, cell_d, res_q};
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            z_q      <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            z_q      <= z_d;
            done_q   <= done_d;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits are kept separately so the overflow term does not
    // depend on where the shift registers happen to be.
    logic xmsb_q, xmsb_d;
    logic ymsb_q, ymsb_d;
    logic ovf_q,  ovf_d;

    always_comb begin
        xmsb_d = xmsb_q;
        ymsb_d = ymsb_q;
        ovf_d  = ovf_q;
        if (accept) begin
            xmsb_d = X[WIDTH-1];
            ymsb_d = Y[WIDTH-1];
        end
        if (finish) begin
            // Overflow only when signs differ and the result sign differs
            // from the minuend sign.
            ovf_d = (xmsb_q ^ ymsb_q) & (cell_d ^ xmsb_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xmsb_q <= 1'b0;
            ymsb_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            xmsb_q <= xmsb_d;
            ymsb_q <= ymsb_d;
            ovf_q  <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign Z    = z_q;

endmodule
